// File: rtl/idiv_pkg.sv
// Shared types and constants for the iterative restoring divider.
package idiv_pkg;

  localparam int unsigned DefaultWidth = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StDone
  } state_e;

  // Step counter runs 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width < 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/idiv_if.sv
// Divider request/response bundle: go with operands in, results and done strobe out.
interface idiv_if #(
  parameter int unsigned WIDTH = idiv_pkg::DefaultWidth
) ();
  logic             go;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;
  logic             div_by_zero;

  modport master (
    output go, in0, in1,
    input  ready, done, quot, rem, div_by_zero
  );

  modport slave (
    input  go, in0, in1,
    output ready, done, quot, rem, div_by_zero
  );
endinterface

// File: rtl/idiv_step.sv
// One combinational restoring-division step: shift in a dividend bit, trial-subtract divisor.
module idiv_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             quot_bit
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff;

  always_comb begin
    shifted  = {rem_in, dvd_bit};
    quot_bit = (shifted >= {1'b0, divisor});
    // Only committed when no borrow, so the result always fits in WIDTH bits.
    diff     = shifted[WIDTH-1:0] - divisor;
    rem_out  = quot_bit ? diff : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/idiv.sv
// Iterative restoring divider, WIDTH+1 cycle fixed latency, one op in flight.
// Define IDIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module idiv
  import idiv_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic   clk,
  input logic   reset,
  idiv_if.slave bus
);

  localparam int unsigned CntW = cnt_width(WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  dvd_q, dvd_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [WIDTH-1:0]  prem_q, prem_d;
  logic              zero_q, zero_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH-1:0]  step_rem;
  logic              step_q;
  logic [WIDTH-1:0]  quot_mag;
  logic [WIDTH-1:0]  mag0;
  logic [WIDTH-1:0]  mag1;
  logic [WIDTH-1:0]  quot_fin;
  logic [WIDTH-1:0]  rem_fin;

  idiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_in   (prem_q),
    .dvd_bit  (dvd_q[WIDTH-1]),
    .divisor  (dvs_q),
    .rem_out  (step_rem),
    .quot_bit (step_q)
  );

  // Dividend register doubles as the quotient shift register.
  assign quot_mag = {dvd_q[WIDTH-2:0], step_q};

`ifdef IDIV_SIGNED_EN
  logic neg_quot_q, neg_quot_d;
  logic neg_rem_q, neg_rem_d;

  always_comb begin
    mag0     = bus.in0[WIDTH-1] ? (~bus.in0 + WIDTH'(1)) : bus.in0;
    mag1     = bus.in1[WIDTH-1] ? (~bus.in1 + WIDTH'(1)) : bus.in1;
    rem_fin  = neg_rem_q ? (~step_rem + WIDTH'(1)) : step_rem;
    quot_fin = zero_q    ? '1
             : neg_quot_q ? (~quot_mag + WIDTH'(1)) : quot_mag;
  end

  always_comb begin
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    if (state_q == StIdle && bus.go) begin
      neg_quot_d = bus.in0[WIDTH-1] ^ bus.in1[WIDTH-1];
      neg_rem_d  = bus.in0[WIDTH-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
    end else begin
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
    end
  end
`else
  always_comb begin
    mag0     = bus.in0;
    mag1     = bus.in1;
    rem_fin  = step_rem;
    quot_fin = zero_q ? '1 : quot_mag;
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    prem_d  = prem_q;
    zero_d  = zero_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (bus.go) begin
          state_d = StBusy;
          cnt_d   = '0;
          dvd_d   = mag0;
          dvs_d   = mag1;
          prem_d  = '0;
          zero_d  = (bus.in1 == '0);
        end
      end
      StBusy: begin
        cnt_d  = cnt_q + CntW'(1);
        dvd_d  = quot_mag;
        prem_d = step_rem;
        if (cnt_q == LastCnt) begin
          state_d = StDone;
          quot_d  = quot_fin;
          rem_d   = rem_fin;
          dbz_d   = zero_q;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      prem_q  <= '0;
      zero_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      prem_q  <= prem_d;
      zero_q  <= zero_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.ready       = (state_q == StIdle);
  assign bus.done        = (state_q == StDone);
  assign bus.quot        = quot_q;
  assign bus.rem         = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_idiv.sv
// Scoreboard bench for idiv: driver pushes expected results, monitor checks on each done.
module tb_idiv;
  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic reset;

  idiv_if #(.WIDTH(W)) bus ();

  idiv #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    logic [31:0]  cyc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   chk_ready_next = 1'b0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    e.cyc = '0;
    e.z   = (b == '0);
`ifdef IDIV_SIGNED_EN
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
      e.q = a;
      e.r = '0;
    end else begin
      e.q = W'($signed(a) / $signed(b));
      e.r = W'($signed(a) % $signed(b));
    end
`else
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
`endif
    return e;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (reset) begin
      chk_ready_next = 1'b0;
    end else begin
      if (chk_ready_next) begin
        check("ready_after_done", W'(bus.ready), W'(1));
        chk_ready_next = 1'b0;
      end
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no done (t=%0t)", $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("quot", bus.quot, e.q);
          check("rem", bus.rem, e.r);
          check("div_by_zero", W'(bus.div_by_zero), W'(e.z));
          check("latency", W'(cyc - e.cyc), W'(W + 1));
          chk_ready_next = 1'b1;
        end
      end
    end
  end

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
    int   waited = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL ready_timeout: got ready=0 expected ready=1 within 200 cycles");
      return;
    end
    bus.go  = 1'b1;
    bus.in0 = a;
    bus.in1 = b;
    @(posedge clk);
    #1;
    e.q = q;
    e.r = r;
    e.z = z;
    e.cyc = cyc - 1;
    sb.push_back(e);
    @(negedge clk);
    bus.go = 1'b0;
    check("ready_drop", W'(bus.ready), W'(0));
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] a, b;
    exp_t         e;
    bit           rdy;
    int           n_acc;

    reset   = 1'b1;
    bus.go  = 1'b0;
    bus.in0 = '0;
    bus.in1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", W'(bus.ready), W'(1));
    check("rst_done", W'(bus.done), W'(0));
    check("rst_quot", bus.quot, '0);
    check("rst_rem", bus.rem, '0);
    check("rst_dbz", W'(bus.div_by_zero), W'(0));
    reset = 1'b0;

    issue(32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    issue(32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, 1'b1);
    issue(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0);
    issue(32'd5, 32'd9, 32'd0, 32'd5, 1'b0);
    drain();

    // Results must hold through idle and the following busy period.
    repeat (6) @(negedge clk);
    check("hold_idle_quot", bus.quot, 32'd0);
    check("hold_idle_rem", bus.rem, 32'd5);
    issue(32'h8000_0000, 32'h8000_0000, 32'd1, 32'd0, 1'b0);
    repeat (5) @(negedge clk);
    check("hold_busy_quot", bus.quot, 32'd0);
    check("hold_busy_rem", bus.rem, 32'd5);
    drain();

`ifdef IDIV_SIGNED_EN
    issue(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
    issue(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
    drain();
`endif

    // go held high with fresh operands each cycle; only idle-cycle operands count.
    n_acc = 0;
    for (int i = 0; i <= 3 * (W + 2); i++) begin
      @(negedge clk);
      a       = W'(1000 + i * 37);
      b       = W'(i % 7 + 1);
      bus.go  = 1'b1;
      bus.in0 = a;
      bus.in1 = b;
      rdy     = bus.ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        e     = model(a, b);
        e.cyc = cyc - 1;
        sb.push_back(e);
        n_acc++;
      end
    end
    @(negedge clk);
    bus.go = 1'b0;
    drain();
    check("held_go_accepts", W'(n_acc), W'(4));

    // Reset mid-operation aborts with no done.
    @(negedge clk);
    bus.go  = 1'b1;
    bus.in0 = 32'd50;
    bus.in1 = 32'd5;
    @(negedge clk);
    bus.go = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_ready", W'(bus.ready), W'(1));
    check("abort_done", W'(bus.done), W'(0));
    check("abort_quot", bus.quot, '0);
    check("abort_rem", bus.rem, '0);
    check("abort_dbz", W'(bus.div_by_zero), W'(0));
    reset = 1'b0;
    repeat (40) @(negedge clk);
    issue(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
    drain();

    for (int i = 0; i < 300; i++) begin
      a = $urandom;
      b = (i % 10 == 0) ? '0 : (W'($urandom) >> $urandom_range(31, 0));
      e = model(a, b);
      issue(a, b, e.q, e.r, e.z);
    end
    drain();

    check("scoreboard_empty", W'(sb.size()), W'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
